mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Initiator side of the data_memory port. It sits in the pipeline MEM stage and turns load/store requests (byte, half, word; signed or unsigned loads) into word-aligned data_memory accesses. Sub-word stores are done as a two-cycle read-modify-write, with a pipeline stall. Little-endian byte lanes.

Parameters:
ADDR_W, 32, byte-address width on the request and memory sides
DATA_W, 32, word width; fixed at 32, since lane logic assumes 4 bytes

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage has a memory operation this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
stall  out  1  upstream must hold req_* stable; the request is not consumed this cycle
resp_valid  out  1  one-cycle pulse, the cycle after a request is consumed
resp_rdata  out  DATA_W  extended load result; holds its value when no load completes
mem_write  out  1  to data_memory write
mem_address  out  ADDR_W  to data_memory address; always {req_addr[ADDR_W-1:2],2'b00}
mem_write_data  out  DATA_W  to data_memory write_data
mem_read_data  in  DATA_W  from data_memory read_data (combinational read of mem_address)

Behaviour:
- Memory contract: read is combinational from mem_address; a write commits at the posedge where mem_write=1.
- States: IDLE, MERGE.
- Reset (sync, active-high) gives:
  - state=IDLE, resp_valid=0, resp_rdata=0, merge register=0.
  - While reset=1: mem_write=0 and stall=0 regardless of inputs.
- Lane select:
  - byte lane = req_addr[1:0]; half lane = req_addr[1].
  - Without the optional feature, low address bits below the access size are ignored (half at addr[0]=1 uses lane addr[1]; word ignores [1:0]).
- Load, IDLE, req_valid & !req_write:
  - mem_write=0, stall=0.
  - Lane is extracted from mem_read_data, extended per req_unsigned and registered into resp_rdata at the posedge.
  - resp_valid=1 the next cycle. Latency is 1 cycle.
- Word store, IDLE:
  - mem_write=1 and mem_write_data=req_wdata in the same cycle; stall=0.
  - resp_valid pulses the next cycle; resp_rdata unchanged.
- Sub-word store, IDLE, size 00/01, cycle 0:
  - stall=1, mem_write=0.
  - At the posedge: capture mem_read_data into the merge register, latch addr/size/wdata, go to MERGE.
- MERGE, cycle 1:
  - stall=0, mem_write=1, mem_address from the latched addr.
  - mem_write_data = merge register with the selected byte/half replaced by the low bits of the latched wdata.
  - req_* seen this cycle is the same transaction; it is consumed and not re-executed.
  - At the posedge: go to IDLE; resp_valid pulses the next cycle.
- Back-to-back requests:
  - Accepted every cycle in IDLE.
  - A new request is examined only in IDLE, so at most one RMW is in flight.
- Load immediately after a store to the same word returns the new data, because the write committed at the preceding edge.
- req_valid=0 in IDLE: mem_write=0, stall=0, resp_valid=0 the next cycle.
- Reset asserted in MERGE: the write is suppressed, state goes to IDLE, memory is unchanged.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output port misaligned (1 bit, reset 0).
  - A request is misaligned if it is a half with addr[0]=1 or a word with addr[1:0]!=0.
  - A misaligned request: no memory write, no RMW, stall=0.
  - Next cycle: resp_valid=1, misaligned=1, resp_rdata=0.
  - misaligned is 0 for every other response.
- Undefined: no port; misaligned requests are silently force-aligned as described above.

Test Plan:
- Word load: mem[12]=0x00000003; lw addr 12 → mem_address=12, mem_write=0, stall=0; next cycle resp_valid=1, resp_rdata=0x00000003.
- Word store: sw addr 20, wdata 0 (mem[20]=5) → same cycle mem_write=1, mem_address=20, mem_write_data=0; following lw 20 returns 0x00000000.
- Byte store RMW: mem[20]=0x11223344; sb addr 21, wdata 0xAB →
  - cycle0: stall=1, mem_write=0.
  - cycle1: stall=0, mem_write=1, mem_write_data=0x1122AB44.
  - lw 20 then returns 0x1122AB44.
- Extension, mem[20]=0x80FF0000:
  - lb 23 → 0xFFFFFF80; lbu 23 → 0x00000080.
  - lh 22 → 0xFFFF80FF; lhu 22 → 0x000080FF.
- Reset in RMW: sh addr 20 wdata 0xBEEF, reset=1 during the MERGE cycle → mem_write=0, stall=0, resp_valid=0 next cycle, mem[20] unchanged.
- Misalignment, mem[12]=3, lw addr 13:
  - With MEM_MISALIGN_TRAP_EN: misaligned=1, resp_valid=1, resp_rdata=0.
  - Without it: resp_rdata=0x00000003.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - MEM-stage request/response and data_memory bus bundle; optional MEM_MISALIGN_TRAP_EN adds misaligned
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misaligned;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output stall, resp_valid, resp_rdata, misaligned, mem_write, mem_address, mem_write_data
    );
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  stall, resp_valid, resp_rdata, misaligned, mem_write, mem_address, mem_write_data
    );
`else
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output stall, resp_valid, resp_rdata, mem_write, mem_address, mem_write_data
    );
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  stall, resp_valid, resp_rdata, mem_write, mem_address, mem_write_data
    );
`endif
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word RMW; optional MEM_MISALIGN_TRAP_EN
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic {IDLE, MERGE} state_t;

    state_t            state;
    logic [DATA_W-1:0] merge_q;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_half;
    logic [15:0]       lat_wdata;

    logic              is_mis;
    logic              sub_store;
    logic [4:0]        ld_shamt;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] load_val;
    logic [4:0]        mg_shamt;
    logic [DATA_W-1:0] field_mask;
    logic [DATA_W-1:0] merge_data;

`ifdef MEM_MISALIGN_TRAP_EN
    // Half at an odd address or word off a word boundary traps instead of accessing memory
    assign is_mis = (bus.req_size == 2'b01 && bus.req_addr[0])
                 || (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
    assign is_mis = 1'b0;
`endif

    assign sub_store = bus.req_valid & bus.req_write & ~bus.req_size[1] & ~is_mis;

    // Load lane extraction and sign/zero extension from the combinational read data
    always_comb begin
        if (bus.req_size[1])
            ld_shamt = 5'd0;
        else if (bus.req_size[0])
            ld_shamt = {bus.req_addr[1], 4'b0000};
        else
            ld_shamt = {bus.req_addr[1:0], 3'b000};
        rd_shift = bus.mem_read_data >> ld_shamt;
        case (bus.req_size)
            2'b00:   load_val = bus.req_unsigned ? {{(DATA_W-8){1'b0}}, rd_shift[7:0]}
                                                 : {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = bus.req_unsigned ? {{(DATA_W-16){1'b0}}, rd_shift[15:0]}
                                                 : {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_shift;
        endcase
    end

    // Replace the latched byte/half lane inside the word captured during the read cycle
    always_comb begin
        mg_shamt   = lat_half ? {lat_addr[1], 4'b0000} : {lat_addr[1:0], 3'b000};
        field_mask = lat_half ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF);
        merge_data = (merge_q & ~(field_mask << mg_shamt))
                   | ((DATA_W'(lat_wdata) & field_mask) << mg_shamt);
    end

    // Memory-side drive and stall; reset forces both write and stall low
    always_comb begin
        bus.stall          = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = {bus.req_addr[ADDR_W-1:2], 2'b00};
        bus.mem_write_data = bus.req_wdata;
        if (state == MERGE) begin
            bus.mem_address    = {lat_addr[ADDR_W-1:2], 2'b00};
            bus.mem_write_data = merge_data;
            bus.mem_write      = ~reset;
        end else if (!reset && bus.req_valid && bus.req_write && !is_mis) begin
            if (bus.req_size[1])
                bus.mem_write = 1'b1;
            else
                bus.stall = 1'b1;
        end
    end

    // Control FSM: IDLE accepts a request every cycle, MERGE finishes the sub-word write
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            merge_q        <= '0;
            lat_addr       <= '0;
            lat_half       <= 1'b0;
            lat_wdata      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            bus.misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.resp_valid <= bus.req_valid & ~sub_store;
`ifdef MEM_MISALIGN_TRAP_EN
                    bus.misaligned <= bus.req_valid & is_mis;
`endif
                    if (bus.req_valid) begin
                        if (is_mis) begin
                            bus.resp_rdata <= '0;
                        end else if (!bus.req_write) begin
                            bus.resp_rdata <= load_val;
                        end else if (sub_store) begin
                            merge_q   <= bus.mem_read_data;
                            lat_addr  <= bus.req_addr;
                            lat_half  <= bus.req_size[0];
                            lat_wdata <= bus.req_wdata[15:0];
                            state     <= MERGE;
                        end
                    end
                end
                MERGE: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    bus.misaligned <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a word-array memory model
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    // data_memory: combinational read, write at posedge; pre_* preloads words between requests
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;
    assign ifc.mem_read_data = mem[ifc.mem_address[7:2]];
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ifc.mem_write)
            mem[ifc.mem_address[7:2]] <= ifc.mem_write_data;
    end

    // Reference model state and per-cycle expectations
    logic [31:0] ref_mem [0:63];
    logic        exp_stall, exp_mw, exp_rv, exp_mis;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic        pend_rv, pend_load, pend_mis;
    logic [31:0] pend_rd;
    logic        chk_on = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] sz, input logic u);
        longint n, lane, scale, span, v;
        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lane  = (n == 4) ? 0 : (longint'(a % 4) / n) * n;
        scale = longint'(1) << (8 * lane);
        span  = longint'(1) << (8 * n);
        v     = (longint'(word) / scale) % span;
        if (!u && n < 4 && v >= span / 2)
            v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] wd);
        longint n, lane, scale, span, field, v;
        n     = (sz == 2'd0) ? 1 : 2;
        lane  = (longint'(a % 4) / n) * n;
        scale = longint'(1) << (8 * lane);
        span  = longint'(1) << (8 * n);
        field = (longint'(word) / scale) % span;
        v     = longint'(word) - field * scale + (longint'(wd) % span) * scale;
        return v[31:0];
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Single compare process: every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("stall", {31'd0, ifc.stall}, {31'd0, exp_stall});
            check("mem_write", {31'd0, ifc.mem_write}, {31'd0, exp_mw});
            check("mem_address", ifc.mem_address, exp_addr);
            if (exp_mw)
                check("mem_write_data", ifc.mem_write_data, exp_wd);
            check("resp_valid", {31'd0, ifc.resp_valid}, {31'd0, exp_rv});
            check("resp_rdata", ifc.resp_rdata, exp_rd);
`ifdef MEM_MISALIGN_TRAP_EN
            check("misaligned", {31'd0, ifc.misaligned}, {31'd0, exp_mis});
`endif
        end
    end

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        exp_rv  = pend_rv;
        exp_mis = pend_mis;
        if (pend_load)
            exp_rd = pend_rd;
        pend_rv   = 1'b0;
        pend_load = 1'b0;
        pend_mis  = 1'b0;
        reset     = 1'b0;
        pre_we    = 1'b0;
    endtask

    task automatic idle();
        begin_cycle();
        ifc.req_valid = 1'b0;
        exp_stall = 1'b0;
        exp_mw    = 1'b0;
        exp_addr  = {ifc.req_addr[31:2], 2'b00};
    endtask

    task automatic idle_poke(input logic [31:0] a, input logic [31:0] v);
        idle();
        pre_we   = 1'b1;
        pre_addr = a[7:2];
        pre_data = v;
        ref_mem[a[7:2]] = v;
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                      input logic [31:0] wd, input logic rst_merge);
        logic [31:0] word;
        begin_cycle();
        ifc.req_valid    = 1'b1;
        ifc.req_write    = w;
        ifc.req_size     = sz;
        ifc.req_unsigned = u;
        ifc.req_addr     = a;
        ifc.req_wdata    = wd;
        word      = ref_mem[a[7:2]];
        exp_addr  = {a[31:2], 2'b00};
        exp_stall = 1'b0;
        exp_mw    = 1'b0;
        pend_rv   = 1'b1;
        if (model_mis(sz, a)) begin
            pend_load = 1'b1;
            pend_rd   = 32'd0;
            pend_mis  = 1'b1;
        end else if (!w) begin
            pend_load = 1'b1;
            pend_rd   = model_load(word, a, sz, u);
        end else if (sz >= 2'd2) begin
            exp_mw = 1'b1;
            exp_wd = wd;
            ref_mem[a[7:2]] = wd;
        end else begin
            exp_stall = 1'b1;
            pend_rv   = 1'b0;
            begin_cycle();
            exp_stall = 1'b0;
            if (rst_merge) begin
                reset     = 1'b1;
                exp_mw    = 1'b0;
                pend_load = 1'b1;
                pend_rd   = 32'd0;
            end else begin
                exp_mw  = 1'b1;
                exp_wd  = model_merge(word, a, sz, wd);
                ref_mem[a[7:2]] = exp_wd;
                pend_rv = 1'b1;
            end
        end
    endtask

    task automatic lit(input string name, input logic [31:0] v);
        @(negedge clk);
        check({name, "_dut"}, ifc.resp_rdata, v);
        check({name, "_model"}, exp_rd, v);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            ref_mem[i] = 32'd0;
        pend_rv = 0; pend_load = 0; pend_mis = 0; pend_rd = 0;
        pre_we = 0; pre_addr = 0; pre_data = 0;
        reset = 1'b1;
        ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_size = 2'b00;
        ifc.req_unsigned = 1'b0; ifc.req_addr = 32'd20; ifc.req_wdata = 32'hAB;
        @(posedge clk);
        #1;
        exp_stall = 0; exp_mw = 0; exp_rv = 0; exp_rd = 0; exp_mis = 0;
        exp_addr = 32'd20;
        chk_on = 1'b1;
        // A second reset cycle with a sub-word store presented: no stall, no write
        begin_cycle();
        reset = 1'b1;
        exp_stall = 0; exp_mw = 0;
        pend_load = 1'b1; pend_rd = 32'd0;

        idle_poke(32'd12, 32'h0000_0003);
        idle_poke(32'd20, 32'h0000_0005);

        op(0, 2'b10, 0, 32'd12, 32'd0, 0); idle(); lit("lw12", 32'h0000_0003);
        op(1, 2'b10, 0, 32'd20, 32'd0, 0);
        op(0, 2'b10, 0, 32'd20, 32'd0, 0); idle(); lit("sw_lw20", 32'h0000_0000);

        idle_poke(32'd20, 32'h1122_3344);
        op(1, 2'b00, 0, 32'd21, 32'h0000_00AB, 0);
        op(0, 2'b10, 0, 32'd20, 32'd0, 0); idle(); lit("sb_lw20", 32'h1122_AB44);

        idle_poke(32'd20, 32'h80FF_0000);
        op(0, 2'b00, 0, 32'd23, 32'd0, 0); idle(); lit("lb23", 32'hFFFF_FF80);
        op(0, 2'b00, 1, 32'd23, 32'd0, 0); idle(); lit("lbu23", 32'h0000_0080);
        op(0, 2'b01, 0, 32'd22, 32'd0, 0); idle(); lit("lh22", 32'hFFFF_80FF);
        op(0, 2'b01, 1, 32'd22, 32'd0, 0); idle(); lit("lhu22", 32'h0000_80FF);

        // Back-to-back mix: loads every cycle, two RMWs, immediate reload
        op(0, 2'b00, 0, 32'd22, 32'd0, 0);
        op(0, 2'b01, 1, 32'd20, 32'd0, 0);
        op(1, 2'b01, 0, 32'd22, 32'h1234_5678, 0);
        op(1, 2'b00, 0, 32'd20, 32'h0000_00C3, 0);
        op(0, 2'b10, 0, 32'd20, 32'd0, 0); idle(); lit("rmw2", 32'h5678_00C3);
        op(0, 2'b11, 1, 32'd20, 32'd0, 0); idle(); lit("rsvd_size", 32'h5678_00C3);

        // Reset during MERGE suppresses the write
        idle_poke(32'd20, 32'h80FF_0000);
        op(1, 2'b01, 0, 32'd20, 32'h0000_BEEF, 1);
        idle();
        op(0, 2'b10, 0, 32'd20, 32'd0, 0); idle(); lit("rst_merge", 32'h80FF_0000);

        // Misaligned accesses
        op(0, 2'b10, 0, 32'd13, 32'd0, 0); idle();
`ifdef MEM_MISALIGN_TRAP_EN
        lit("lw13", 32'h0000_0000);
`else
        lit("lw13", 32'h0000_0003);
`endif
        op(1, 2'b01, 0, 32'd21, 32'h0000_CAFE, 0);
        op(0, 2'b10, 0, 32'd20, 32'd0, 0); idle();
`ifdef MEM_MISALIGN_TRAP_EN
        lit("sh21", 32'h80FF_0000);
`else
        lit("sh21", 32'h80FF_CAFE);
`endif
        op(1, 2'b10, 0, 32'd14, 32'hDEAD_BEEF, 0);
        op(0, 2'b10, 0, 32'd12, 32'd0, 0); idle();
        idle();
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
